if_fetch: RTL and testbench

Instruction fetch unit sitting directly downstream of the program counter in the IF stage. It accepts fetch addresses from `pc`, issues one request at a time to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. Decode drains the FIFO over a valid/ready handshake. A jump flush discards all buffered and in-flight instructions.

---
 rtl/if_fetch_if.sv | 30 +++
 rtl/if_fetch.sv | 133 +++++++++++++
 tb/tb_if_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Bus bundle for the instruction fetch unit: pc request, imem request/ack and decode drain.
// master = fetch unit, slave = its environment (pc, imem, decode).
interface if_fetch_if;
    // pc side: a fetch is accepted on a cycle where pc_valid & pc_ready are both 1.
    // decode side: the head is consumed on a cycle where inst_valid & inst_ready are both 1.
    // imem side: imem_req/imem_addr are held until the cycle imem_ack is 1; that cycle carries imem_rdata.
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    modport master (
        input  pc_addr, pc_valid, flush, imem_ack, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_err
    );

    modport slave (
        output pc_addr, pc_valid, flush, imem_ack, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst_valid, inst, inst_pc, inst_err
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch unit: one outstanding imem request at a time, returned words buffered
// with their PCs in a small FIFO that decode drains; flush discards buffered and in-flight data.
module if_fetch #(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    if_fetch_if.master  bus,
    output logic [1:0]  dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [31:0]           mem_inst [FIFO_DEPTH];
    logic [31:0]           mem_pc   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_err;

    logic        accept, push, pop, req_set, req_clr;
    logic [31:0] push_inst, push_pc;
    logic        push_err;

    assign dbg_state     = state;
    assign bus.pc_ready  = (state == IDLE) && (count < DEPTH_C) && !bus.flush;
    assign accept        = bus.pc_valid && bus.pc_ready;
    assign bus.inst_valid = (count != '0);
    assign pop           = bus.inst_valid && bus.inst_ready && !bus.flush;

    always_comb begin
        state_nxt = state;
        req_set   = 1'b0;
        req_clr   = 1'b0;
        push      = 1'b0;
        push_inst = NOP_INST;
        push_pc   = bus.pc_addr;
        push_err  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.pc_addr[1:0] == 2'b00) begin
                        req_set   = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        // Misaligned: answer locally with a flagged NOP, memory is never asked.
                        push     = 1'b1;
                        push_err = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    req_clr   = 1'b1;
                    state_nxt = IDLE;
                    if (!bus.flush) begin
                        push      = 1'b1;
                        push_inst = bus.imem_rdata;
                        push_pc   = bus.imem_addr;
                    end
                end else if (bus.flush) begin
                    // The request stays up until memory answers; its data is then thrown away.
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    req_clr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= '0;
        end else if (req_set) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= bus.pc_addr;
        end else if (req_clr) begin
            bus.imem_req  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem_inst[wr_ptr] <= push_inst;
            mem_pc[wr_ptr]   <= push_pc;
            mem_err[wr_ptr]  <= push_err;
        end
    end

    assign bus.inst     = bus.inst_valid ? mem_inst[rd_ptr] : '0;
    assign bus.inst_pc  = bus.inst_valid ? mem_pc[rd_ptr]   : '0;
    assign bus.inst_err = bus.inst_valid ? mem_err[rd_ptr]  : 1'b0;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a per-cycle vector table plus hand-written sequences
// for flush-while-outstanding and asynchronous reset during a request.
module tb_if_fetch;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_cmp;
    int         n_err;

    if_fetch_if bus ();

    if_fetch #(.FIFO_DEPTH(2), .NOP_INST(32'h0000_0013)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        logic        fl;
        logic        ack;
        logic [31:0] rd;
        logic        ir;
        logic        e_rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_err;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic pv, logic [31:0] pa, logic fl, logic ack, logic [31:0] rd,
                               logic ir, logic e_rdy, logic e_req, logic [31:0] e_addr,
                               logic e_val, logic [31:0] e_inst, logic [31:0] e_pc,
                               logic e_err, logic [1:0] e_st);
        vec_t r;
        r.pv = pv; r.pa = pa; r.fl = fl; r.ack = ack; r.rd = rd; r.ir = ir;
        r.e_rdy = e_rdy; r.e_req = e_req; r.e_addr = e_addr; r.e_val = e_val;
        r.e_inst = e_inst; r.e_pc = e_pc; r.e_err = e_err; r.e_st = e_st;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drv(input logic pv, input logic [31:0] pa, input logic fl,
                       input logic ack, input logic [31:0] rd, input logic ir);
        @(negedge clk);
        bus.pc_valid   = pv;
        bus.pc_addr    = pa;
        bus.flush      = fl;
        bus.imem_ack   = ack;
        bus.imem_rdata = rd;
        bus.inst_ready = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic req, input logic [31:0] addr,
                              input logic val, input logic [31:0] inst, input logic [31:0] pc,
                              input logic err, input logic [1:0] st);
        check({tag, ".imem_req"},   {31'd0, bus.imem_req},   {31'd0, req});
        check({tag, ".imem_addr"},  bus.imem_addr,           addr);
        check({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, {31'd0, val});
        check({tag, ".inst"},       bus.inst,                inst);
        check({tag, ".inst_pc"},    bus.inst_pc,             pc);
        check({tag, ".inst_err"},   {31'd0, bus.inst_err},   {31'd0, err});
        check({tag, ".state"},      {30'd0, dbg_state},      {30'd0, st});
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        drv(t.pv, t.pa, t.fl, t.ack, t.rd, t.ir);
        #1;
        check({tag, ".pc_ready"}, {31'd0, bus.pc_ready}, {31'd0, t.e_rdy});
        tick();
        check_regs(tag, t.e_req, t.e_addr, t.e_val, t.e_inst, t.e_pc, t.e_err, t.e_st);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.pc_valid = 1'b0; bus.pc_addr = '0; bus.flush = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
        check("reset.pc_ready", {31'd0, bus.pc_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        //        pv pa     fl ack rd            ir  rdy req addr   val inst          pc     err st
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        0,  1, 0, 32'h0, 0, 32'h0,        32'h0,  0, S_IDLE));
        vecs.push_back(v(1, 32'h0,  0, 0, 32'h0,        0,  1, 1, 32'h0, 0, 32'h0,        32'h0,  0, S_REQ));
        vecs.push_back(v(0, 32'h0,  0, 1, 32'h00500093, 0,  0, 0, 32'h0, 1, 32'h00500093, 32'h0,  0, S_IDLE));
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        1,  1, 0, 32'h0, 0, 32'h0,        32'h0,  0, S_IDLE));
        // fill to full with decode stalled
        vecs.push_back(v(1, 32'h0,  0, 0, 32'h0,        0,  1, 1, 32'h0, 0, 32'h0,        32'h0,  0, S_REQ));
        vecs.push_back(v(0, 32'h0,  0, 1, 32'h11111111, 0,  0, 0, 32'h0, 1, 32'h11111111, 32'h0,  0, S_IDLE));
        vecs.push_back(v(1, 32'h4,  0, 0, 32'h0,        0,  1, 1, 32'h4, 1, 32'h11111111, 32'h0,  0, S_REQ));
        vecs.push_back(v(0, 32'h0,  0, 1, 32'h22222222, 0,  0, 0, 32'h4, 1, 32'h11111111, 32'h0,  0, S_IDLE));
        vecs.push_back(v(1, 32'h8,  0, 0, 32'h0,        0,  0, 0, 32'h4, 1, 32'h11111111, 32'h0,  0, S_IDLE));
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        1,  0, 0, 32'h4, 1, 32'h22222222, 32'h4,  0, S_IDLE));
        vecs.push_back(v(1, 32'h8,  0, 0, 32'h0,        0,  1, 1, 32'h8, 1, 32'h22222222, 32'h4,  0, S_REQ));
        // push and pop in one cycle
        vecs.push_back(v(0, 32'h0,  0, 1, 32'h33333333, 1,  0, 0, 32'h8, 1, 32'h33333333, 32'h8,  0, S_IDLE));
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        1,  1, 0, 32'h8, 0, 32'h0,        32'h0,  0, S_IDLE));
        // misaligned fetch
        vecs.push_back(v(1, 32'h6,  0, 0, 32'h0,        0,  1, 0, 32'h8, 1, 32'h00000013, 32'h6,  1, S_IDLE));
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        1,  1, 0, 32'h8, 0, 32'h0,        32'h0,  0, S_IDLE));
        // two buffered entries, then flush with pop and pc_valid
        vecs.push_back(v(1, 32'h21, 0, 0, 32'h0,        0,  1, 0, 32'h8, 1, 32'h00000013, 32'h21, 1, S_IDLE));
        vecs.push_back(v(1, 32'h22, 0, 0, 32'h0,        0,  1, 0, 32'h8, 1, 32'h00000013, 32'h21, 1, S_IDLE));
        vecs.push_back(v(1, 32'h30, 1, 0, 32'h0,        1,  0, 0, 32'h8, 0, 32'h0,        32'h0,  0, S_IDLE));
        vecs.push_back(v(0, 32'h0,  0, 0, 32'h0,        0,  1, 0, 32'h8, 0, 32'h0,        32'h0,  0, S_IDLE));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Flush while 0x10 is outstanding, ack three cycles later
        drv(1, 32'h10, 0, 0, 32'h0, 0);
        tick();
        check_regs("drop.issue", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, S_REQ);
        drv(0, 32'h0, 1, 0, 32'h0, 0);
        tick();
        check_regs("drop.flush", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, S_DROP);
        drv(1, 32'h44, 0, 0, 32'h0, 0);
        #1;
        check("drop.pc_ready", {31'd0, bus.pc_ready}, 32'd0);
        tick();
        check_regs("drop.wait", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, S_DROP);
        drv(0, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        tick();
        check_regs("drop.ack", 1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
        drv(1, 32'h40, 0, 0, 32'h0, 0);
        tick();
        check_regs("drop.refetch", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, S_REQ);
        drv(0, 32'h0, 0, 1, 32'h00A00113, 0);
        tick();
        check_regs("drop.deliver", 1'b0, 32'h40, 1'b1, 32'h00A00113, 32'h40, 1'b0, S_IDLE);
        drv(0, 32'h0, 0, 0, 32'h0, 1);
        tick();

        // Flush and ack in the same cycle: data discarded, straight back to IDLE
        drv(1, 32'h50, 0, 0, 32'h0, 0);
        tick();
        drv(0, 32'h0, 1, 1, 32'hCAFEF00D, 0);
        tick();
        check_regs("flush_ack", 1'b0, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);

        // Asynchronous reset while a request is outstanding and one entry is buffered
        drv(1, 32'h61, 0, 0, 32'h0, 0);
        tick();
        drv(1, 32'h64, 0, 0, 32'h0, 0);
        tick();
        check_regs("rst.pre", 1'b1, 32'h64, 1'b1, 32'h00000013, 32'h61, 1'b1, S_REQ);
        drv(0, 32'h0, 0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("rst.async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBADBAD00;
        #1;
        check("rst.pc_ready", {31'd0, bus.pc_ready}, 32'd1);
        tick();
        check_regs("rst.stray_ack", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE);
        drv(0, 32'h0, 0, 0, 32'h0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
